// File: rtl/bias_add.sv
// Bias-add stage: adds the per-group bias word to 16-lane partial sums,
// saturates to 32 bits, applies optional ReLU and streams to the output store.
module bias_add #(
  parameter int unsigned C_LANES          = 16,
  parameter int unsigned C_DATA_WIDTH     = 32,
  parameter int unsigned C_RAM_ADDR_WIDTH = 10,
  parameter int unsigned C_PIX_WIDTH      = 16,
  parameter int unsigned C_RD_LAT         = 2
) (
  input  logic                              I_clk,
  input  logic                              I_rst,
  input  logic                              I_ap_start,
  output logic                              O_ap_done,
  input  logic [C_PIX_WIDTH-1:0]            I_pix_num,
  input  logic [C_RAM_ADDR_WIDTH-1:0]       I_cog_num,
  input  logic                              I_relu_en,
  output logic [C_RAM_ADDR_WIDTH-1:0]       O_braddr,
  input  logic [C_LANES*C_DATA_WIDTH-1:0]   I_brdata,
  input  logic                              I_sum_valid,
  output logic                              O_sum_ready,
  input  logic [C_LANES*C_DATA_WIDTH-1:0]   I_sum_data,
  output logic                              O_res_valid,
  input  logic                              I_res_ready,
  output logic [C_LANES*C_DATA_WIDTH-1:0]   O_res_data
);

  localparam int unsigned BW     = C_LANES * C_DATA_WIDTH;
  localparam int unsigned DW     = C_DATA_WIDTH;
  localparam int unsigned AW     = C_RAM_ADDR_WIDTH;
  localparam int unsigned PW     = C_PIX_WIDTH;
  localparam int unsigned WAIT_W = $clog2(C_RD_LAT + 1) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_start_d;
  logic              r_done;
  logic [PW-1:0]     r_pix_num;
  logic [AW-1:0]     r_cog_num;
  logic              r_relu;
  logic [PW-1:0]     r_pix_cnt;
  logic [AW-1:0]     r_grp_cnt;
  logic [AW-1:0]     r_braddr;
  logic [WAIT_W-1:0] r_wait;
  logic [BW-1:0]     r_bias;
  logic              r_res_valid;
  logic [BW-1:0]     r_res_data;

  logic              w_start_edge;
  logic              w_zero;
  logic              w_prime_done;
  logic              w_sum_ready;
  logic              w_accept;
  logic              w_last_pix;
  logic              w_last_grp;
  logic [BW-1:0]     w_res;

  assign w_start_edge = I_ap_start && !r_start_d;
  assign w_zero       = (I_pix_num == '0) || (I_cog_num == '0);
  assign w_prime_done = (r_wait == WAIT_W'(C_RD_LAT));
  assign w_sum_ready  = (r_state == S_RUN) && (!r_res_valid || I_res_ready);
  assign w_accept     = w_sum_ready && I_sum_valid;
  assign w_last_pix   = (r_pix_cnt == r_pix_num - PW'(1));
  assign w_last_grp   = (r_grp_cnt == r_cog_num - AW'(1));

  assign O_ap_done   = r_done;
  assign O_braddr    = r_braddr;
  assign O_sum_ready = w_sum_ready;
  assign O_res_valid = r_res_valid;
  assign O_res_data  = r_res_data;

  // Per-lane 33-bit add, clamp to the 32-bit signed range, then optional ReLU.
  for (genvar g = 0; g < C_LANES; g++) begin : g_lane
    logic [DW:0]   w_s;
    logic [DW-1:0] w_sat;
    assign w_s = {I_sum_data[g*DW + DW-1], I_sum_data[g*DW +: DW]}
               + {r_bias[g*DW + DW-1], r_bias[g*DW +: DW]};
    assign w_sat = (w_s[DW] != w_s[DW-1])
                 ? (w_s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                 : w_s[DW-1:0];
    assign w_res[g*DW +: DW] = (r_relu && w_sat[DW-1]) ? '0 : w_sat;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = w_zero ? S_DONE : S_PRIME;
      S_PRIME: if (w_prime_done) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_state_nxt = w_last_grp ? S_DRAIN : S_PRIME;
      S_DRAIN: if (!r_res_valid) w_state_nxt = S_DONE;
      S_DONE:  if (!I_ap_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run control: latched config, counters, bias read address and bias capture.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_start_d <= 1'b0;
      r_done    <= 1'b0;
      r_pix_num <= '0;
      r_cog_num <= '0;
      r_relu    <= 1'b0;
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
      r_braddr  <= '0;
      r_wait    <= '0;
      r_bias    <= '0;
    end else begin
      r_start_d <= I_ap_start;
      r_done    <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_pix_num <= I_pix_num;
            r_cog_num <= I_cog_num;
            r_relu    <= I_relu_en;
            r_pix_cnt <= '0;
            r_grp_cnt <= '0;
            r_braddr  <= '0;
            r_wait    <= '0;
          end
        end
        S_PRIME: begin
          if (w_prime_done) r_bias <= I_brdata;
          else              r_wait <= r_wait + WAIT_W'(1);
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_pix_cnt <= '0;
              // Address moves only on entry to PRIME, so no read is in flight.
              if (!w_last_grp) begin
                r_grp_cnt <= r_grp_cnt + AW'(1);
                r_braddr  <= r_braddr + AW'(1);
                r_wait    <= '0;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Single output register; a new accept overwrites a beat handed off this cycle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_res;
    end else if (I_res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_add.sv
// Self-checking bench for bias_add: random sums against a lane-arithmetic
// reference model with a delayed-read bias RAM model.
module tb_bias_add;

  localparam int unsigned L   = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned PW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned BW  = L * DW;

  logic          clk = 1'b0;
  logic          I_rst;
  logic          I_ap_start;
  logic          O_ap_done;
  logic [PW-1:0] I_pix_num;
  logic [AW-1:0] I_cog_num;
  logic          I_relu_en;
  logic [AW-1:0] O_braddr;
  logic [BW-1:0] I_brdata;
  logic          I_sum_valid;
  logic          O_sum_ready;
  logic [BW-1:0] I_sum_data;
  logic          O_res_valid;
  logic          I_res_ready;
  logic [BW-1:0] O_res_data;

  always #5 clk = ~clk;

  bias_add #(.C_LANES(L), .C_DATA_WIDTH(DW), .C_RAM_ADDR_WIDTH(AW),
             .C_PIX_WIDTH(PW), .C_RD_LAT(LAT)) dut (
    .I_clk(clk), .I_rst(I_rst), .I_ap_start(I_ap_start), .O_ap_done(O_ap_done),
    .I_pix_num(I_pix_num), .I_cog_num(I_cog_num), .I_relu_en(I_relu_en),
    .O_braddr(O_braddr), .I_brdata(I_brdata), .I_sum_valid(I_sum_valid),
    .O_sum_ready(O_sum_ready), .I_sum_data(I_sum_data), .O_res_valid(O_res_valid),
    .I_res_ready(I_res_ready), .O_res_data(O_res_data));

  // Bias RAM with a LAT-stage read pipeline.
  logic [BW-1:0] ram [16];
  logic [BW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= ram[O_braddr[3:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign I_brdata = rd_pipe[LAT-1];

  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [BW-1:0] exp_q [$];
  int            ready_cyc [$];
  int            m_pix, m_acc, n_out, run_ticks;
  logic          m_relu;
  logic          held, took;
  logic [BW-1:0] held_data, last_res, first_res, sat_vec;
  logic [31:0]   fill_val;
  int            fill_mode, vmode, rmode;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] model(input logic [BW-1:0] sum, input logic [BW-1:0] bias,
                                          input logic relu);
    logic [BW-1:0] r;
    longint s;
    for (int i = 0; i < L; i++) begin
      s = longint'($signed(sum[i*DW +: DW])) + longint'($signed(bias[i*DW +: DW]));
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (relu && s < 0) s = 0;
      r[i*DW +: DW] = 32'(s);
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] gen_sum();
    logic [BW-1:0] v;
    for (int i = 0; i < L; i++)
      v[i*DW +: DW] = (fill_mode == 0) ? fill_val : $urandom();
    if (fill_mode == 2) v = sat_vec;
    return v;
  endfunction

  // One cycle: sample just after the negedge, update the model, advance.
  task automatic tick();
    int grp;
    #1;
    if (held) begin
      chk("hold_valid", BW'(O_res_valid), BW'(1));
      chk("hold_data", O_res_data, held_data);
    end
    if (O_res_valid && !I_res_ready) chk("ready_when_blocked", BW'(O_sum_ready), BW'(0));
    if (O_res_valid && I_res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", BW'(1), BW'(0));
      else chk("res_data", O_res_data, exp_q.pop_front());
      if (n_out == 0) first_res = O_res_data;
      last_res = O_res_data;
      n_out++;
    end
    if (O_sum_ready) ready_cyc.push_back(cyc);
    took = O_sum_ready && I_sum_valid;
    if (took) begin
      if (m_pix == 0) chk("accept_when_zero", BW'(1), BW'(0));
      else begin
        grp = m_acc / m_pix;
        chk("braddr", BW'(O_braddr), BW'(grp));
        exp_q.push_back(model(I_sum_data, ram[grp[3:0]], m_relu));
        m_acc++;
      end
    end
    held      = O_res_valid && !I_res_ready;
    held_data = O_res_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_inputs(input int i);
    logic [3:0] bp;
    bp = 4'b1001;
    if (!I_sum_valid || took) begin
      I_sum_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      I_sum_data  = gen_sum();
    end
    case (rmode)
      0:       I_res_ready = 1'b1;
      1:       I_res_ready = bp[3 - (i % 4)];
      default: I_res_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic start_run(input int pix, input int cog, input logic relu);
    I_pix_num = PW'(pix);
    I_cog_num = AW'(cog);
    I_relu_en = relu;
    m_pix = pix; m_relu = relu; m_acc = 0; n_out = 0;
    exp_q.delete(); ready_cyc.delete();
    held = 1'b0; took = 1'b0;
    I_sum_valid = 1'b0;
    I_ap_start  = 1'b1;
  endtask

  task automatic run(input int pix, input int cog, input logic relu);
    start_run(pix, cog, relu);
    run_ticks = 0;
    for (int i = 0; i < 4000 && !O_ap_done; i++) begin
      drive_inputs(i);
      tick();
      run_ticks++;
    end
    chk("done_reached", BW'(O_ap_done), BW'(1));
    chk("beats_out", BW'(n_out), BW'(pix * cog));
    chk("queue_empty", BW'(exp_q.size()), BW'(0));
    I_sum_valid = 1'b0;
    I_ap_start  = 1'b0;
    tick();
    chk("done_fall", BW'(O_ap_done), BW'(0));
  endtask

  initial begin
    I_rst = 1'b1; I_ap_start = 1'b0; I_pix_num = '0; I_cog_num = '0; I_relu_en = 1'b0;
    I_sum_valid = 1'b0; I_sum_data = '0; I_res_ready = 1'b0;
    held = 1'b0; took = 1'b0; m_pix = 0; m_acc = 0; n_out = 0; m_relu = 1'b0;
    fill_mode = 0; fill_val = 32'd10; vmode = 0; rmode = 0; sat_vec = '0;
    for (int a = 0; a < 16; a++)
      for (int i = 0; i < L; i++) ram[a][i*DW +: DW] = $urandom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_done", BW'(O_ap_done), BW'(0));
    chk("rst_valid", BW'(O_res_valid), BW'(0));
    chk("rst_data", O_res_data, BW'(0));
    chk("rst_braddr", BW'(O_braddr), BW'(0));
    chk("rst_ready", BW'(O_sum_ready), BW'(0));
    I_rst = 1'b0;
    @(negedge clk);

    // Basic two-group run with known biases.
    for (int i = 0; i < L; i++) begin
      ram[0][i*DW +: DW] = 32'(i);
      ram[1][i*DW +: DW] = 32'd100;
    end
    fill_mode = 0; fill_val = 32'd10; vmode = 0; rmode = 0;
    run(4, 2, 1'b0);
    chk("t1_first_lane0", BW'(first_res[31:0]), BW'(10));
    chk("t1_first_lane15", BW'(first_res[15*DW +: DW]), BW'(25));
    chk("t1_last_lane7", BW'(last_res[7*DW +: DW]), BW'(110));

    // Saturation and ReLU.
    ram[0][0*DW +: DW] = 32'h0000_0020;
    ram[0][1*DW +: DW] = 32'hFFFF_FFF0;
    ram[0][2*DW +: DW] = 32'd2;
    for (int i = 0; i < L; i++) sat_vec[i*DW +: DW] = $urandom();
    sat_vec[0*DW +: DW] = 32'h7FFF_FFF0;
    sat_vec[1*DW +: DW] = 32'h8000_0005;
    sat_vec[2*DW +: DW] = 32'hFFFF_FFFB;
    fill_mode = 2;
    run(1, 1, 1'b0);
    chk("sat_pos", BW'(last_res[0*DW +: DW]), BW'(32'h7FFF_FFFF));
    chk("sat_neg", BW'(last_res[1*DW +: DW]), BW'(32'h8000_0000));
    chk("neg_norelu", BW'(last_res[2*DW +: DW]), BW'(32'hFFFF_FFFD));
    run(1, 1, 1'b1);
    chk("relu_sat_neg", BW'(last_res[1*DW +: DW]), BW'(0));
    chk("relu_neg", BW'(last_res[2*DW +: DW]), BW'(0));
    chk("relu_pos", BW'(last_res[0*DW +: DW]), BW'(32'h7FFF_FFFF));

    // Back-pressure 1,0,0,1 with continuous valid, random data.
    for (int a = 0; a < 4; a++)
      for (int i = 0; i < L; i++) ram[a][i*DW +: DW] = $urandom();
    fill_mode = 1; vmode = 0; rmode = 1;
    run(5, 3, 1'b0);

    // Group-change stall: one accept then LAT+1 stall cycles per group.
    rmode = 0;
    run(1, 3, 1'b0);
    chk("stall_ready_count", BW'(ready_cyc.size()), BW'(3));
    if (ready_cyc.size() == 3) begin
      chk("stall_gap0", BW'(ready_cyc[1] - ready_cyc[0]), BW'(LAT + 2));
      chk("stall_gap1", BW'(ready_cyc[2] - ready_cyc[1]), BW'(LAT + 2));
    end

    // Zero group count: done on the next cycle, nothing accepted.
    run(4, 0, 1'b0);
    chk("zero_done_latency", BW'(run_ticks), BW'(1));
    chk("zero_no_ready", BW'(ready_cyc.size()), BW'(0));

    // Random valid / random ready, ReLU on.
    vmode = 1; rmode = 2;
    run(7, 4, 1'b1);

    // Reset in RUN while a result is held.
    vmode = 0; rmode = 0;
    start_run(4, 2, 1'b0);
    for (int i = 0; i < 50 && !(O_res_valid && dut.r_state == 3'd2); i++) begin
      drive_inputs(i);
      tick();
    end
    chk("pre_rst_valid", BW'(O_res_valid), BW'(1));
    I_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", BW'(O_res_valid), BW'(0));
    chk("midrst_data", O_res_data, BW'(0));
    chk("midrst_braddr", BW'(O_braddr), BW'(0));
    chk("midrst_ready", BW'(O_sum_ready), BW'(0));
    chk("midrst_done", BW'(O_ap_done), BW'(0));
    @(negedge clk);
    I_rst = 1'b0; I_ap_start = 1'b0; I_sum_valid = 1'b0;
    held = 1'b0; exp_q.delete();
    tick();
    fill_mode = 1; vmode = 1; rmode = 2;
    run(3, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_add.md
Name: bias_add

Overview:
- Downstream consumer of the bias loader's read port.
- Takes 16-lane 32-bit convolution partial sums per output pixel, adds the per-channel-group bias word read from the bias RAM, applies optional ReLU and saturation, and streams results to the output-store stage.
- Steps the bias read address once per output-channel group.
- Ap-style start/done control.

Parameters:
C_LANES, 16, number of parallel output channels per group
C_DATA_WIDTH, 32, signed width of each sum/bias/result lane
C_RAM_ADDR_WIDTH, 10, bias RAM read address width
C_PIX_WIDTH, 16, width of pixel-per-group count
C_RD_LAT, 2, cycles from O_braddr change to valid I_brdata

Ports:
I_clk  input  1  clock
I_rst  input  1  synchronous active-high reset
I_ap_start  input  1  level; a 0->1 edge starts a run
O_ap_done  output  1  high from run end until I_ap_start falls
I_pix_num  input  C_PIX_WIDTH  pixels per channel group, sampled at start
I_cog_num  input  C_RAM_ADDR_WIDTH  number of channel groups, sampled at start
I_relu_en  input  1  ReLU enable, sampled at start
O_braddr  output  C_RAM_ADDR_WIDTH  bias RAM read address (group index)
I_brdata  input  C_LANES*C_DATA_WIDTH  bias word; lane i = bits [32i+31:32i]
I_sum_valid  input  1  partial-sum beat valid
O_sum_ready  output  1  partial-sum beat accepted when valid&&ready
I_sum_data  input  C_LANES*C_DATA_WIDTH  partial sums, same lane packing
O_res_valid  output  1  result beat valid
I_res_ready  input  1  downstream ready
O_res_data  output  C_LANES*C_DATA_WIDTH  biased results

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-run aborts the run immediately. Any held output beat is discarded.
- States: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE -> PRIME on the I_ap_start 0->1 edge:
  - Latch I_pix_num, I_cog_num and I_relu_en.
  - Clear pix_cnt and grp_cnt; set O_braddr=0.
  - If I_pix_num==0 or I_cog_num==0, go IDLE -> DONE directly; no beats are accepted.
- PRIME:
  - Wait counter runs C_RD_LAT cycles with O_sum_ready=0.
  - Then capture I_brdata into the bias register and go to RUN.
- RUN:
  - O_sum_ready = !O_res_valid || I_res_ready (single output register, no bubble under full throughput).
  - On accept: register the result, O_res_valid=1, pix_cnt++.
  - On accept with pix_cnt==pix_num-1:
    - Clear pix_cnt.
    - If grp_cnt==cog_num-1, go to DRAIN.
    - Else grp_cnt++, O_braddr++, go to PRIME.
- Output register:
  - Holds O_res_data/O_res_valid stable while O_res_valid&&!I_res_ready.
  - Clears O_res_valid on handshake with no new accept.
  - Same-cycle output handshake and new accept: the new beat replaces the old one.
- Latency: 1 cycle from input accept to O_res_valid.
- Group change costs C_RD_LAT+1 stall cycles on input. The output register may still drain during the stall.
- DRAIN: wait until O_res_valid==0, then go to DONE.
- DONE: O_ap_done=1; go to IDLE with O_ap_done=0 when I_ap_start==0.
- A start edge is ignored outside IDLE.
- Arithmetic, per lane:
  - s = sign-extended 33-bit sum + bias.
  - Saturate: s>0x7FFFFFFF -> 0x7FFFFFFF; s<-0x80000000 -> 0x80000000.
  - If relu_en and result negative -> 0.
- I_sum_valid without O_sum_ready (IDLE/PRIME/DRAIN/DONE) is ignored; the beat is not consumed.
- O_braddr holds its value outside PRIME transitions, and must not change while a RAM read is in flight.

Test Plan:
1. pix_num=4, cog_num=2, relu off, bias grp0 lanes=lane index, grp1 lanes=100; sums all 10, I_res_ready=1 -> 4 beats lanes 10..25, then 4 beats all 110; O_braddr 0 then 1; O_ap_done after 8th output.
2. Saturation: sum 0x7FFFFFF0 + bias 0x20 -> 0x7FFFFFFF; sum 0x80000005 + bias -0x10 -> 0x80000000; relu on with sum -5 + bias 2 -> 0.
3. Back-pressure: I_res_ready toggles 1,0,0,1 with continuous valid -> O_res_data stable during low; no beat lost or duplicated; O_sum_ready low when held and not ready.
4. Group-change stall: pix_num=1, cog_num=3, continuous I_sum_valid -> O_sum_ready high exactly once per C_RD_LAT+1 cycles after PRIME; three results with biases of addresses 0,1,2.
5. Zero count: cog_num=0 with start edge -> O_ap_done high next cycle, O_sum_ready never asserted.
6. Reset mid-run: assert I_rst during RUN with O_res_valid=1 -> next cycle all outputs 0, state IDLE; a new start edge then runs cleanly from O_braddr=0.
